// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - register map, status layout and serialiser states for uart_tx_mmio
package uart_tx_mmio_pkg;

   localparam logic [31:0] OFS_TXDATA = 32'h0;
   localparam logic [31:0] OFS_STATUS = 32'h4;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   function automatic logic [31:0] pack_status(input logic ovf, input logic busy,
                                               input logic empty, input logic full);
      logic [31:0] s;
      s           = '0;
      s[ST_FULL]  = full;
      s[ST_EMPTY] = empty;
      s[ST_BUSY]  = busy;
      s[ST_OVF]   = ovf;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - pipeline data-bus write/read port seen by the UART transmitter
interface uart_tx_mmio_if;
   logic        mem_wren;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;

   modport master (output mem_wren, output mem_wmask, output mem_wdata, output mem_addr,
                   input mem_rdata);
   modport slave  (input mem_wren, input mem_wmask, input mem_wdata, input mem_addr,
                   output mem_rdata);
endinterface

// File: rtl/uart_tx_mmio_fifo.sv
// rtl/uart_tx_mmio_fifo.sv - synchronous FIFO with combinational head, full-push dropped unless popping
module uart_tx_mmio_fifo #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A slot freed on the same edge lets a push into a full FIFO through.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter: address decode, status, baud counter, FSM
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int          CLK_DIV   = 868,
   parameter int          FIFO_AW   = 3
) (
   input  logic           clk,
   input  logic           rstn,
   uart_tx_mmio_if.slave  bus,
   output logic           tx,
   output logic           tx_busy
);

   localparam int            CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   tx_state_t     state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          ovf;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic          push;
   logic          pop;
   logic          sel_status;
   logic          clr_ovf;
   logic          unused_bits;

   assign sel_status  = (bus.mem_addr == BASE_ADDR + OFS_STATUS);
   assign push        = bus.mem_wren & bus.mem_wmask[0] & (bus.mem_addr == BASE_ADDR + OFS_TXDATA);
   assign clr_ovf     = bus.mem_wren & bus.mem_wmask[0] & sel_status & bus.mem_wdata[ST_OVF];
   assign pop         = (state == S_IDLE) & ~fifo_empty;
   assign tx_busy     = (state != S_IDLE) | ~fifo_empty;
   assign unused_bits = ^{bus.mem_wdata[31:8], bus.mem_wmask[3:1]};

   uart_tx_mmio_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .din   (bus.mem_wdata[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A fresh overflow takes precedence over a software clear in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf           <= 1'b0;
         bus.mem_rdata <= '0;
      end else begin
         if (push & fifo_full & ~pop) ovf <= 1'b1;
         else if (clr_ovf)            ovf <= 1'b0;
         bus.mem_rdata <= sel_status ? pack_status(ovf, tx_busy, fifo_empty, fifo_full) : '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  shift    <= fifo_dout;
                  tx       <= 1'b0;
                  baud_cnt <= DIV_LAST;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (baud_cnt == '0) begin
                  tx       <= shift[0];
                  shift    <= {1'b0, shift[7:1]};
                  bit_idx  <= '0;
                  baud_cnt <= DIV_LAST;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            S_DATA: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= DIV_LAST;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     tx      <= shift[0];
                     shift   <= {1'b0, shift[7:1]};
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            S_STOP: begin
               if (baud_cnt == '0) state <= S_IDLE;
               else                baud_cnt <= baud_cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed and random stores checked against a frame-timing reference model
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam logic [31:0] STAT  = 32'h1000_0004;
   localparam int          DIV   = 4;
   localparam int          AW    = 2;
   localparam int          DEPTH = 4;
   localparam int          FRAME = 10 * DIV;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic tx;
   logic tx_busy;

   uart_tx_mmio_if bus();

   uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_AW(AW)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .bus     (bus),
      .tx      (tx),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Reference: every accepted byte with the edge it was stored and the edge it leaves the FIFO.
   int         acc_push[$];
   int         acc_pop[$];
   logic [7:0] acc_byte[$];
   int         last_pop = -1000;
   logic       m_ovf    = 1'b0;
   int         st_edge  = 0;

   int         got_start[$];
   logic [7:0] got_byte[$];
   bit         got_fmt[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int occupancy(input int e);
      int n = 0;
      foreach (acc_push[i]) if (acc_push[i] < e && acc_pop[i] >= e) n++;
      return n;
   endfunction

   function automatic bit pop_at(input int e);
      foreach (acc_pop[i]) if (acc_pop[i] == e) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit frame_active(input int e);
      foreach (acc_pop[i]) if (e > acc_pop[i] && e <= acc_pop[i] + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] status_at(input int e);
      logic [31:0] s = '0;
      int n = occupancy(e);
      s[0] = (n == DEPTH);
      s[1] = (n == 0);
      s[2] = (n != 0) || frame_active(e);
      s[3] = m_ovf;
      return s;
   endfunction

   task automatic model_reset();
      acc_push.delete();
      acc_pop.delete();
      acc_byte.delete();
      last_pop = -1000;
      m_ovf    = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
      int e;
      int p;
      @(negedge clk);
      bus.mem_wren  = 1'b1;
      bus.mem_wmask = m;
      bus.mem_wdata = d;
      bus.mem_addr  = a;
      e       = cyc + 1;
      st_edge = e;
      if (m[0] && a == BASE) begin
         if (occupancy(e) < DEPTH || pop_at(e)) begin
            p = (last_pop + FRAME + 1 > e + 1) ? last_pop + FRAME + 1 : e + 1;
            acc_push.push_back(e);
            acc_pop.push_back(p);
            acc_byte.push_back(d[7:0]);
            last_pop = p;
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (m[0] && a == STAT && d[3]) m_ovf = 1'b0;
   endtask

   task automatic bus_idle();
      @(negedge clk);
      bus.mem_wren  = 1'b0;
      bus.mem_wmask = 4'h0;
      bus.mem_wdata = '0;
      bus.mem_addr  = '0;
   endtask

   task automatic read_status(input string tag);
      logic [31:0] exp_s;
      @(negedge clk);
      bus.mem_wren  = 1'b0;
      bus.mem_wmask = 4'h0;
      bus.mem_addr  = STAT;
      exp_s = status_at(cyc + 1);
      @(negedge clk);
      bus.mem_addr  = '0;
      chk(tag, bus.mem_rdata, exp_s);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_done();
      int t = cyc + 2;
      if (acc_pop.size() > 0 && acc_pop[$] + FRAME + 3 > t) t = acc_pop[$] + FRAME + 3;
      wait_until(t);
   endtask

   task automatic check_frames(input string tag);
      int n = (got_byte.size() < acc_byte.size()) ? got_byte.size() : acc_byte.size();
      chk({tag, "_count"}, got_byte.size(), acc_byte.size());
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_byte%0d", tag, i), got_byte[i], acc_byte[i]);
         chk($sformatf("%s_start%0d", tag, i), got_start[i], acc_pop[i]);
         chk($sformatf("%s_fmt%0d", tag, i), got_fmt[i], 1'b1);
      end
      got_byte.delete();
      got_start.delete();
      got_fmt.delete();
      acc_push.delete();
      acc_pop.delete();
      acc_byte.delete();
   endtask

   // Line monitor: samples each bit in the middle of its bit time, abandons frames cut by reset.
   int         mon_start;
   logic [7:0] mon_b;
   bit         mon_alive;
   bit         mon_fmt;

   task automatic mon_wait(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (rstn !== 1'b1) mon_alive = 1'b0;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && tx === 1'b0) begin
            mon_start = cyc;
            mon_alive = 1'b1;
            mon_fmt   = 1'b1;
            mon_b     = '0;
            mon_wait(DIV / 2);
            if (tx !== 1'b0) mon_fmt = 1'b0;
            for (int i = 0; i < 8; i++) begin
               mon_wait(DIV);
               mon_b[i] = tx;
            end
            mon_wait(DIV);
            if (tx !== 1'b1) mon_fmt = 1'b0;
            if (mon_alive) begin
               got_start.push_back(mon_start);
               got_byte.push_back(mon_b);
               got_fmt.push_back(mon_fmt);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          r;
      int          gap;
      int          p;
      logic [31:0] a;
      logic [3:0]  m;
      logic [7:0]  b0;

      bus.mem_wren  = 1'b0;
      bus.mem_wmask = 4'h0;
      bus.mem_wdata = '0;
      bus.mem_addr  = '0;
      rstn = 1'b0;
      repeat (4) @(negedge clk);
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", tx_busy, 1'b0);
      chk("reset_rdata", bus.mem_rdata, 32'h0);
      rstn = 1'b1;
      read_status("reset_status");
      @(negedge clk);
      chk("rdata_other_cycle", bus.mem_rdata, 32'h0);

      do_store(BASE, 4'hF, 32'h0000_0041);
      bus_idle();
      wait_until(st_edge + 40);
      chk("single_busy_hi", tx_busy, 1'b1);
      wait_until(st_edge + 41);
      chk("single_busy_lo", tx_busy, 1'b0);
      wait_done();
      check_frames("single");

      do_store(BASE, 4'hF, 32'h55);
      do_store(BASE, 4'hF, 32'hAA);
      do_store(BASE, 4'hF, 32'h00);
      do_store(BASE, 4'hF, 32'hFF);
      read_status("b2b_status");
      wait_done();
      check_frames("b2b");

      for (int i = 0; i < 6; i++) do_store(BASE, 4'h1, $urandom);
      read_status("ovf_status");
      chk("ovf_accepted", acc_byte.size(), 5);
      wait_done();
      check_frames("ovf");
      read_status("ovf_still_set");
      do_store(STAT, 4'h1, 32'h8);
      read_status("ovf_cleared");

      do_store(BASE, 4'hE, 32'h77);
      do_store(BASE + 32'h8, 4'hF, 32'h78);
      do_store(BASE + 32'h1000, 4'hF, 32'h79);
      bus_idle();
      repeat (50) @(negedge clk);
      chk("filter_busy", tx_busy, 1'b0);
      chk("filter_tx", tx, 1'b1);
      read_status("filter_status");
      check_frames("filter");

      repeat (30) begin
         r = $urandom_range(0, 9);
         if (r < 6) begin
            repeat ($urandom_range(1, 4)) begin
               m = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 3) != 0);
               do_store(BASE, m, $urandom);
            end
            bus_idle();
         end else if (r == 6) begin
            a = ($urandom_range(0, 1) == 0) ? BASE + 32'h8 : BASE + 32'h1000;
            do_store(a, 4'hF, $urandom);
            bus_idle();
         end else if (r == 7) begin
            do_store(STAT, 4'hF, $urandom);
            bus_idle();
         end else begin
            read_status("rnd_status");
         end
         gap = $urandom_range(0, 25);
         repeat (gap) @(negedge clk);
      end
      wait_done();
      check_frames("rnd");
      read_status("rnd_final_status");

      b0 = 8'($urandom) & 8'hF7;
      do_store(BASE, 4'hF, {24'h0, b0});
      do_store(BASE, 4'hF, $urandom);
      do_store(BASE, 4'hF, $urandom);
      bus_idle();
      p = acc_pop[0];
      wait_until(p + 4 + 3 * DIV + 1);
      chk("rst_mid_before", tx, b0[3]);
      rstn = 1'b0;
      #1;
      chk("rst_mid_tx", tx, 1'b1);
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_mid_busy_in_reset", tx_busy, 1'b0);
      rstn = 1'b1;
      repeat (60) @(negedge clk);
      chk("rst_mid_busy_after", tx_busy, 1'b0);
      read_status("rst_mid_status");
      check_frames("rst_mid");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
